// File: rtl/twos_to_signmag_serial_pkg.sv
// Shared types and constants for the serial two's-complement to sign-magnitude decoder.
// Imported by the handshake interface, the bit-slice and the top level.
package twos_signmag_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int W_DEFAULT = 4;

  // Counter width able to hold the values 0..w.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/twos_to_signmag_serial_if.sv
// Valid/ready handshake bundle for the serial sign-magnitude decoder:
// word input side plus sign/magnitude result side.
interface twos_to_signmag_serial_if
  import twos_signmag_pkg::*;
#(
  parameter int W = W_DEFAULT
);

  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] di;
  logic                out_valid;
  logic                out_ready;
  logic                sign;
  logic        [W-1:0] mag;

  // Decoder side
  modport slave (
    input  in_valid,
    input  di,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sign,
    output mag
  );

  // Producer/consumer side
  modport master (
    output in_valid,
    output di,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sign,
    input  mag
  );

endinterface

// File: rtl/twos_to_signmag_serial_neg_cell.sv
// Combinational negation bit-slice: conditional XOR invert followed by a half adder.
// Chained through an external carry flip-flop it computes inv ? -x : x one bit per cycle.
module serial_neg_cell (
  input  logic bit_in,
  input  logic inv,
  input  logic cin,
  output logic res,
  output logic cout
);

  logic b;

  always_comb begin
    b    = bit_in ^ inv;
    res  = b ^ cin;
    cout = b & cin;
  end

endmodule

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder. A word is accepted in IDLE,
// walked LSB-first through one negation slice over W cycles, then held in DONE until taken.
module twos_to_signmag_serial
  import twos_signmag_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  twos_to_signmag_serial_if.slave    bus
);

  localparam int CNT_W = cnt_width(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t state_q;
  state_t state_d;

  logic [W-1:0]     sr_q;
  logic [W-1:0]     res_q;
  logic [W-1:0]     res_next;
  logic             sign_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic [W-1:0]     mag_q;
  logic             sign_out_q;
  logic             out_valid_q;

  logic             slice_res;
  logic             slice_cout;
  logic             accept;
  logic             last_shift;
  logic             release_out;

  serial_neg_cell u_cell (
    .bit_in (sr_q[0]),
    .inv    (sign_q),
    .cin    (carry_q),
    .res    (slice_res),
    .cout   (slice_cout)
  );

  // The result fills from the top so that after W shifts bit 0 sits at the LSB.
  assign res_next = {slice_res, res_q[W-1:1]};

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    last_shift  = 1'b0;
    release_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          last_shift = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          release_out = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- Serial datapath: load on accept, one bit per SHIFT edge ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      res_q   <= '0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      sr_q    <= bus.di;
      sign_q  <= bus.di[W-1];
      carry_q <= bus.di[W-1];
      cnt_q   <= '0;
    end else if (state_q == SHIFT) begin
      sr_q    <= sr_q >> 1;
      res_q   <= res_next;
      carry_q <= slice_cout;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // ---- Result registers: only touched on the final shift and on release ----
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q       <= '0;
      sign_out_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (last_shift) begin
      mag_q       <= res_next;
      sign_out_q  <= sign_q;
      out_valid_q <= 1'b1;
    end else if (release_out) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sign      = sign_out_q;
  assign bus.mag       = mag_q;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Directed self-checking bench for twos_to_signmag_serial (W=4) with hand-computed results.
module tb_twos_to_signmag_serial;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  twos_to_signmag_serial_if #(.W(W)) bus ();

  twos_to_signmag_serial #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks    = 0;
  int n_errors    = 0;
  int edge_cnt    = 0;
  int accept_edge = 0;
  int prev_accept = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present a word at a negedge; returns at the negedge after the accepting edge.
  task automatic accept_word(input string tag, input logic [W-1:0] word, input bit hold_valid);
    chk({tag, "_in_ready_pre"}, 32'(bus.in_ready), 32'd1);
    bus.di       = word;
    bus.in_valid = 1'b1;
    @(negedge clk);
    accept_edge = edge_cnt;
    if (!hold_valid) bus.in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_result(input string tag, input logic exp_sign, input logic [W-1:0] exp_mag);
    int n = 0;
    while (!bus.out_valid && n < 3 * W) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(edge_cnt - accept_edge), 32'(W));
    chk({tag, "_sign"}, 32'(bus.sign), 32'(exp_sign));
    chk({tag, "_mag"}, 32'(bus.mag), 32'(exp_mag));
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_rel_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_rel_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.di        = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_sign", 32'(bus.sign), 32'd0);
    chk("reset_mag", 32'(bus.mag), 32'd0);

    // -3 -> sign 1, mag 3
    accept_word("neg3", 4'b1101, 1'b0);
    wait_result("neg3", 1'b1, 4'b0011);
    release_result("neg3");

    // +7 then -8 back-to-back with in_valid held; di scrambled while busy
    accept_word("pos7", 4'b0111, 1'b1);
    bus.di = 4'b0101;
    wait_result("pos7", 1'b0, 4'b0111);
    bus.di      = 4'b1000;
    prev_accept = accept_edge;
    @(negedge clk);
    chk("pos7_back_idle", 32'(bus.in_ready), 32'd1);
    chk("pos7_back_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    accept_edge  = edge_cnt;
    bus.in_valid = 1'b0;
    chk("b2b_spacing", 32'(accept_edge - prev_accept), 32'(W + 2));
    wait_result("neg8", 1'b1, 4'b1000);
    release_result("neg8");

    // zero and -1
    accept_word("zero", 4'b0000, 1'b0);
    wait_result("zero", 1'b0, 4'b0000);
    release_result("zero");
    accept_word("neg1", 4'b1111, 1'b0);
    wait_result("neg1", 1'b1, 4'b0001);
    release_result("neg1");

    // -6 with consumer stalled for 5 cycles
    bus.out_ready = 1'b0;
    accept_word("neg6", 4'b1010, 1'b0);
    wait_result("neg6", 1'b1, 4'b0110);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_sign", 32'(bus.sign), 32'd1);
      chk("stall_mag", 32'(bus.mag), 32'h6);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    release_result("neg6");

    // reset on the 2nd SHIFT edge discards the conversion
    accept_word("abort", 4'b1001, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_mag", 32'(bus.mag), 32'd0);
    chk("abort_sign", 32'(bus.sign), 32'd0);
    accept_word("pos2", 4'b0010, 1'b0);
    wait_result("pos2", 1'b0, 4'b0010);
    release_result("pos2");

    // reset and in_valid together: no word accepted
    rst          = 1'b1;
    bus.di       = 4'b0101;
    bus.in_valid = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_vs_valid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_vs_valid_out_valid", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/twos_to_signmag_serial.md
Name: twos_to_signmag_serial

Overview:
- Bit-serial decoder from W-bit two's-complement to sign-magnitude form.
- Performs the inverse of the team's conditional-invert/add-one negation stage: accepts one signed word, then processes it LSB-first through a single invert/half-add bit-slice with a carry flip-flop.
- Returns SIGN and unsigned MAG.
- Sits between the datapath result bus and display/BCD logic; valid/ready handshake on both sides.

Parameters:
- W, 4, word width in bits; legal for W >= 2.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  DI holds a word to convert.
- IN_READY  out  1  block can accept a word; high only in IDLE.
- DI  in  W  two's-complement input word.
- OUT_VALID  out  1  SIGN/MAG hold a completed result.
- OUT_READY  in  1  consumer accepts the result.
- SIGN  out  1  sign of the last converted word (1 = negative).
- MAG  out  W  unsigned magnitude of the last converted word.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RST.
- State machine: IDLE, SHIFT, DONE.
- Reset: state IDLE, OUT_VALID=0, SIGN=0, MAG=0, count=0, carry=0, shift registers=0. IN_READY=1 after reset, because it is decoded from state==IDLE.
- IDLE:
  - IN_READY=1.
  - On an edge with IN_VALID=1: load DI into the input shift register; sign_q <= DI[W-1]; carry <= DI[W-1]; count <= 0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (one bit per edge, LSB first):
  - b = sr[0] XOR sign_q.
  - res = b XOR carry; carry <= b AND carry.
  - res shifts into the MSB of the result register; sr shifts right; count++.
  - On the W-th SHIFT edge: MAG <= completed result; SIGN <= sign_q; OUT_VALID <= 1; go to DONE.
  - IN_READY=0; IN_VALID is ignored.
- DONE:
  - OUT_VALID=1; MAG and SIGN are stable.
  - On an edge with OUT_READY=1: OUT_VALID <= 0; go to IDLE.
  - While OUT_READY=0: hold everything, for any number of cycles.
- Latency:
  - OUT_VALID rises exactly W edges after the accepting edge.
  - Minimum spacing between accepts is W+2 edges: accept, W shifts, release, then back to IDLE.
- Output hold: MAG and SIGN change only on the final SHIFT edge. They keep their last value through IDLE and the next SHIFT.
- Arithmetic:
  - MAG = |DI| as a W-bit unsigned value.
  - The most-negative input -2^(W-1) gives MAG = 2^(W-1) (MSB set, no overflow) with SIGN=1.
  - Input 0 gives MAG=0, SIGN=0.
  - Final carry-out is discarded; it can only be 1 for input 0 with sign_q=1, which cannot occur.
- Counter: count is ceil(log2(W+1)) bits wide. The SHIFT exit compares count==W-1 on the current edge. No wrap occurs.
- Reset mid-operation: RST=1 in any state forces the full reset values on that edge. A partial conversion is discarded; OUT_VALID=0, MAG=0.
- Simultaneous RST and IN_VALID: reset wins and no word is accepted.

Decomposition:
- Shared package twos_signmag_pkg:
  - state_t enum {IDLE, SHIFT, DONE}.
  - Default width constant W_DEFAULT=4.
- One sub-module, serial_neg_cell: combinational bit-slice, inputs bit, inv, cin; outputs res, cout. It is an XOR invert followed by a half adder.
- The top level holds the FSM, counter, shift registers and output registers.

Test Plan:
- Reset for 2 cycles, then idle → IN_READY=1, OUT_VALID=0, SIGN=0, MAG=4'b0000.
- DI=4'b1101 (-3), IN_VALID for 1 cycle, OUT_READY=1 → OUT_VALID rises 4 edges after accept with SIGN=1, MAG=4'b0011; returns to IDLE next edge.
- DI=4'b0111 (+7), then DI=4'b1000 (-8) back-to-back, IN_VALID held high → results SIGN=0/MAG=0111 then SIGN=1/MAG=1000. Accepts are 6 edges apart; DI changes while IN_READY=0 are ignored.
- DI=4'b0000 → SIGN=0, MAG=0000; DI=4'b1111 (-1) → SIGN=1, MAG=0001.
- DI=4'b1010 (-6), OUT_READY held 0 for 5 cycles → OUT_VALID, SIGN=1, MAG=0110 held stable and IN_READY=0 throughout; completes on the first OUT_READY=1 edge.
- Accept DI=4'b1001, assert RST on the 2nd SHIFT edge → next cycle state IDLE, IN_READY=1, OUT_VALID=0, MAG=0000. A following DI=4'b0010 converts to SIGN=0, MAG=0010.
